// File: rtl/mult_pkg.sv
// Shared FSM state encoding for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Multiplier sequencer: IDLE/COMPUTE/DONE state machine plus the bit counter
// that walks the multiplier bits during COMPUTE.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic [$clog2(WIDTH):0] count_o,
  output logic [1:0]             state_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  mult_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        count_d = '0;
        state_d = start_i ? ST_COMPUTE : ST_IDLE;
      end
      ST_COMPUTE: begin
        if (count_q == LAST_BIT) begin
          state_d = ST_DONE;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        // The unused encoding recovers straight to IDLE.
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign count_o = count_q;
  assign state_o = state_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, with
// unsigned or two's-complement operands selected per operation.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  function automatic logic signed [PW-1:0] extend_operand(input logic [WIDTH-1:0] v,
                                                          input logic is_signed);
    return is_signed ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
  endfunction

  logic [CW-1:0] count;
  logic [1:0]    state;
  mult_state_t   cur_state;

  mult_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .count_o (count),
    .state_o (state)
  );

  assign cur_state = mult_state_t'(state);

  logic signed [PW-1:0] a_ext_q, a_ext_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 signed_q, signed_d;
  logic signed [PW-1:0] acc_q, acc_d;
  logic [PW-1:0]        product_q, product_d;

  logic                 accept;
  logic                 computing;
  logic                 last_cycle;
  logic                 b_bit;
  logic signed [PW-1:0] partial;

  assign accept     = start_i && (cur_state == ST_IDLE || cur_state == ST_DONE);
  assign computing  = (cur_state == ST_COMPUTE);
  assign last_cycle = computing && (count == LAST_BIT);
  assign b_bit      = |(b_q & (WIDTH'(1) << count));
  assign partial    = a_ext_q << count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ext_q   <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      a_ext_q   <= a_ext_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    a_ext_d   = a_ext_q;
    b_d       = b_q;
    signed_d  = signed_q;
    acc_d     = acc_q;
    product_d = product_q;
    if (accept) begin
      a_ext_d  = extend_operand(a_i, signed_i);
      b_d      = b_i;
      signed_d = signed_i;
      acc_d    = '0;
    end else if (computing && b_bit) begin
      // The sign bit of a two's-complement multiplier carries weight -2^(W-1).
      if (signed_q && count == LAST_BIT) acc_d = acc_q - partial;
      else                               acc_d = acc_q + partial;
    end
    if (last_cycle) product_d = acc_d;
  end

  assign product_o = product_q;
  assign busy_o    = computing;
  assign done_o    = (cur_state == ST_DONE);
  assign state_o   = state;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomized and directed bench for the sequential multiplier, WIDTH=8 and WIDTH=4.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st8, sg8, bz8, d8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  s8;
  logic        st4, sg4, bz4, d4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [1:0]  s4;

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(st8), .signed_i(sg8), .a_i(a8), .b_i(b8),
    .product_o(p8), .busy_o(bz8), .done_o(d8), .state_o(s8)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(st4), .signed_i(sg4), .a_i(a4), .b_i(b4),
    .product_o(p4), .busy_o(bz4), .done_o(d4), .state_o(s4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, reduce mod 2^(2w).
  function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    longint x, y, r;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    r = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return 64'(r);
  endfunction

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] exp, prev;
    int busy_n, hold_bad, early;
    exp = 16'(model(8, 32'(a), 32'(b), s));
    prev = p8;
    busy_n = 0; hold_bad = 0; early = 0;
    a8 = a; b8 = b; sg8 = s; st8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        st8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
      end
      busy_n += int'(bz8);
      if (p8 !== prev) hold_bad++;
      if (d8) early++;
    end
    check_eq("busy8_cycles", 64'(busy_n), 64'd8);
    check_eq("hold8_during_compute", 64'(hold_bad + early), 64'd0);
    @(negedge clk);
    check_eq("done8_at_cycle9", 64'({d8, bz8, s8}), 64'b1010);
    check_eq($sformatf("prod8 %0h*%0h s=%0d", a, b, s), 64'(p8), 64'(exp));
    @(negedge clk);
    check_eq("done8_single_pulse", 64'({d8, s8}), 64'd0);
  endtask

  task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] exp;
    int cyc;
    exp = 8'(model(4, 32'(a), 32'(b), s));
    a4 = a; b4 = b; sg4 = s; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
    cyc = 1;
    while (!d4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done4_cycle", 64'(cyc), 64'd5);
    check_eq($sformatf("prod4 %0h*%0h s=%0d", a, b, s), 64'(p4), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    int ndone, dcyc;
    logic [15:0] dprod;
    rst = 1'b1;
    st8 = 0; sg8 = 0; a8 = 0; b8 = 0;
    st4 = 0; sg4 = 0; a4 = 0; b4 = 0;
    repeat (2) @(negedge clk);
    check_eq("reset8_outputs", 64'({p8, bz8, d8, s8}), 64'd0);
    check_eq("reset4_outputs", 64'({p4, bz4, d4, s4}), 64'd0);
    rst = 1'b0;

    mul8(8'd255, 8'd255, 1'b0);
    mul8(8'h80, 8'h80, 1'b1);
    mul8(8'hFF, 8'h7F, 1'b1);
    mul8(8'h05, 8'hFD, 1'b1);

    // start_i during COMPUTE must be ignored
    a8 = 8'd3; b8 = 8'd4; sg8 = 1'b0; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    @(negedge clk);
    @(negedge clk); a8 = 8'd9; b8 = 8'd9; st8 = 1'b1;
    ndone = 0; dcyc = 0; dprod = '0;
    for (int c = 4; c <= 16; c++) begin
      @(negedge clk);
      st8 = 1'b0;
      if (d8) begin ndone++; dcyc = c; dprod = p8; end
    end
    check_eq("ignore_start_ndone", 64'(ndone), 64'd1);
    check_eq("ignore_start_cycle", 64'(dcyc), 64'd9);
    check_eq("ignore_start_prod", 64'(dprod), 64'd12);

    // reset mid-COMPUTE aborts the operation
    a8 = 8'd200; b8 = 8'd100; sg8 = 1'b0; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("abort_state_prod", 64'({p8, bz8, d8, s8}), 64'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d8) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    mul8(8'd200, 8'd100, 1'b0);

    // reset and start on the same edge: reset wins
    rst = 1'b1; st8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    @(negedge clk); rst = 1'b0; st8 = 1'b0;
    check_eq("rst_beats_start", 64'({bz8, s8}), 64'd0);

    // back-to-back with start_i held high
    a8 = 8'd6; b8 = 8'd7; sg8 = 1'b0; st8 = 1'b1;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 40 && ndone < 2; c++) begin
      @(negedge clk);
      if (d8) begin
        ndone++;
        check_eq($sformatf("b2b_cycle_%0d", ndone), 64'(c), 64'(9 * ndone));
        check_eq($sformatf("b2b_prod_%0d", ndone), 64'(p8), (ndone == 1) ? 64'd42 : 64'd0);
        a8 = 8'h00; b8 = 8'hFF;
        if (ndone == 2) st8 = 1'b0;
      end
    end
    check_eq("b2b_ndone", 64'(ndone), 64'd2);
    @(negedge clk);
    check_eq("b2b_idle_after", 64'({d8, s8}), 64'd0);

    for (int i = 0; i < 30; i++)
      mul8(8'($urandom), 8'($urandom), 1'($urandom));

    mul4(4'hF, 4'hF, 1'b0);
    mul4(4'h8, 4'h7, 1'b1);
    mul4(4'h8, 4'h8, 1'b1);
    for (int i = 0; i < 12; i++)
      mul4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk_i  input  1  the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i  input  1  request to start a multiply; sampled each edge.
REQ-005 The block SHALL have port signed_i  input  1  operand mode: 1 = two's complement, 0 = unsigned.
REQ-006 The block SHALL have port a_i  input  WIDTH  multiplicand.
REQ-007 The block SHALL have port b_i  input  WIDTH  multiplier.
REQ-008 The block SHALL have port product_o  output  2*WIDTH  registered result.
REQ-009 The block SHALL have port busy_o  output  1  high while a multiply is in progress.
REQ-010 The block SHALL have port done_o  output  1  one-cycle pulse marking a new valid product_o.
REQ-011 The block SHALL have port state_o  output  2  current FSM state encoding.

Function
REQ-012 The FSM SHALL have states IDLE (0), COMPUTE (1) and DONE (2); encoding 3 is illegal and SHALL return to IDLE on the next edge.
REQ-013 start_i SHALL be accepted only in IDLE or DONE; on acceptance a_i, b_i and signed_i are captured, the accumulator and bit counter clear, and the state goes to COMPUTE.
REQ-014 start_i in COMPUTE SHALL be ignored, with no effect on captured operands, counter or result.
REQ-015 COMPUTE SHALL last exactly WIDTH cycles, processing multiplier bit k (k = counter, 0..WIDTH-1) in each cycle.
REQ-016 Per cycle, if captured b bit k is 1 the accumulator SHALL add (A << k), where A is the captured a zero-extended (unsigned) or sign-extended (signed) to 2*WIDTH.
REQ-017 In signed mode, for k = WIDTH-1, the accumulator SHALL instead subtract (A << k).
REQ-018 All accumulator arithmetic SHALL be modulo 2^(2*WIDTH).
REQ-019 After the WIDTH-th COMPUTE cycle the state SHALL go to DONE, with product_o loaded from the final accumulator and done_o high for exactly that one cycle.
REQ-020 The result SHALL appear exactly WIDTH+1 edges after the accepting edge: done_o high in the cycle following edge WIDTH+1.
REQ-021 product_o SHALL hold its value until the next DONE or a reset; it SHALL NOT change during COMPUTE.
REQ-022 busy_o SHALL be high exactly while the state is COMPUTE.
REQ-023 DONE SHALL go to IDLE when start_i is low, or to COMPUTE when start_i is high (back-to-back operation, throughput of one result per WIDTH+1 cycles).
REQ-024 Changes on a_i, b_i or signed_i after the accepting edge SHALL NOT affect the in-flight result.
REQ-025 Signed-mode results SHALL be exact for all inputs, including most-negative x most-negative = +2^(2*WIDTH-2).

Reset
REQ-026 When rst_i is high at an edge, the state SHALL become IDLE and the counter, captured operands and accumulator SHALL clear.
REQ-027 On that reset edge, product_o SHALL become 0, and busy_o and done_o SHALL become 0.
REQ-028 Reset mid-COMPUTE SHALL abort the operation: no done_o pulse for it, and product_o = 0.
REQ-029 When rst_i and start_i are high at the same edge, reset SHALL win and the start SHALL be dropped.

Structure
REQ-030 Package mult_pkg SHALL hold the state enum typedef (mult_state_t, 2 bits) and the constants ST_IDLE, ST_COMPUTE and ST_DONE.
REQ-031 The FSM plus bit counter SHALL be a sub-module, mult_seq_ctrl (ports clk_i, rst_i, start_i, count_o, state_o), parametrised by WIDTH.
REQ-032 The datapath (operand and accumulator registers, add/subtract) SHALL live in the top module.
REQ-033 Counter width SHALL be $clog2(WIDTH)+1.

Verification
REQ-034 WIDTH=8, unsigned, a=255, b=255, start one cycle -> busy_o for 8 cycles, done_o at cycle 9, product_o=0xFE01.
REQ-035 WIDTH=8, signed: a=0x80, b=0x80 -> 0x4000; a=0xFF, b=0x7F -> 0xFF81; a=0x05, b=0xFD -> 0xFFF1.
REQ-036 WIDTH=8: start a=3, b=4; pulse start_i with a=9, b=9 at COMPUTE cycle 3 -> ignored, product_o=12, one done_o pulse.
REQ-037 WIDTH=8: start a=200, b=100; assert rst_i at COMPUTE cycle 4 -> state_o=0, product_o=0, no done_o; a fresh start then yields the correct result.
REQ-038 WIDTH=8: start_i held high continuously with new operands on each DONE cycle -> done_o every 9 cycles with correct products (6x7=42, then 0x0 x 0xFF=0).
REQ-039 WIDTH=4 instance: unsigned 15x15 -> 0xE1; signed 0x8x0x7 -> 0xC8; signed 0x8x0x8 -> 0x40; done_o at cycle 5.
